// File: rtl/shift_pkg.sv
// Shared encodings and helpers for the pipelined shifter (shift_unit / shift_stage).
package shift_pkg;

    localparam int MODE_W   = 3;
    localparam int SH_MAX_W = 64;

    typedef enum logic [MODE_W-1:0] {
        SH_SLL = 3'b000,
        SH_SRL = 3'b001,
        SH_SRA = 3'b010,
        SH_ROR = 3'b011,
        SH_ROL = 3'b100
    } shift_mode_e;

    // Every mode is reduced to one of these right-direction operations at entry.
    typedef enum logic [1:0] {
        K_PASS = 2'd0,
        K_SHR  = 2'd1,
        K_ROR  = 2'd2
    } op_kind_e;

    // Reverse the low n bits of d; result lands in the low n bits.
    function automatic logic [SH_MAX_W-1:0] bit_rev(input logic [SH_MAX_W-1:0] d, input int n);
        logic [SH_MAX_W-1:0] r;
        r = {<<{d}};
        return r >> (SH_MAX_W - n);
    endfunction

endpackage

// File: rtl/shift_stage.sv
// One elastic stage of the shifter: conditional right shift/rotate by STEP, then register.
// SHIFT_FLAGS_EN adds the carry bit to the stage payload.
module shift_stage
    import shift_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int STEP  = 1,
    parameter int AMT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [AMT_W-1:0] in_amt,
    input  op_kind_e         in_kind,
    input  logic             in_fill,
    input  logic             in_rev,
`ifdef SHIFT_FLAGS_EN
    input  logic             in_carry,
    output logic             out_carry,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [AMT_W-1:0] out_amt,
    output op_kind_e         out_kind,
    output logic             out_fill,
    output logic             out_rev
);

    // STEP == WIDTH is the "shift by >= WIDTH" stage, indexed by the amount MSB.
    localparam int BIT = $clog2(STEP);

    logic [WIDTH-1:0] sh_data;

    generate
        if (STEP >= WIDTH) begin : g_full
            // A full-width rotate is the identity, so only shifts act here.
            always_comb begin
                sh_data = in_data;
                if (in_amt[BIT] && in_kind == K_SHR)
                    sh_data = {WIDTH{in_fill}};
            end
        end else begin : g_part
            always_comb begin
                sh_data = in_data;
                if (in_amt[BIT]) begin
                    case (in_kind)
                        K_SHR:   sh_data = {{STEP{in_fill}}, in_data[WIDTH-1:STEP]};
                        K_ROR:   sh_data = {in_data[STEP-1:0], in_data[WIDTH-1:STEP]};
                        default: sh_data = in_data;
                    endcase
                end
            end
        end
    endgenerate

    assign in_ready = !out_valid || out_ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_amt   <= '0;
            out_kind  <= K_PASS;
            out_fill  <= 1'b0;
            out_rev   <= 1'b0;
        end else if (in_ready) begin
            out_valid <= in_valid;
            if (in_valid) begin
                out_data <= sh_data;
                out_amt  <= in_amt;
                out_kind <= in_kind;
                out_fill <= in_fill;
                out_rev  <= in_rev;
            end
        end
    end

`ifdef SHIFT_FLAGS_EN
    // Last bit leaving the low end: in_data[STEP-1], or the MSB for the full-width shift.
    localparam int TAP = (STEP >= WIDTH) ? WIDTH - 1 : STEP - 1;

    logic sh_carry;

    always_comb begin
        sh_carry = in_carry;
        if (in_amt[BIT] && (in_kind == K_SHR || (in_kind == K_ROR && STEP < WIDTH)))
            sh_carry = in_data[TAP];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            out_carry <= 1'b0;
        else if (in_ready && in_valid)
            out_carry <= sh_carry;
    end
`endif

endmodule

// File: rtl/shift_unit.sv
// Pipelined barrel shifter/rotator (SLL/SRL/SRA/ROR/ROL), one elastic stage per amount bit.
// Define SHIFT_FLAGS_EN to add the out_zero/out_carry flag outputs.
module shift_unit
    import shift_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int AMT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] indata,
    input  logic [AMT_W-1:0] amount,
    input  logic [2:0]       mode,
    output logic             out_valid,
    input  logic             out_ready,
`ifdef SHIFT_FLAGS_EN
    output logic             out_zero,
    output logic             out_carry,
`endif
    output logic [WIDTH-1:0] outdata
);

    // Index 0 is the entry side, index k+1 the registered output of stage k.
    logic [AMT_W:0]             vld_pipe;
    logic [AMT_W:0]             rdy_pipe;
    logic [AMT_W:0][WIDTH-1:0]  dat_pipe;
    logic [AMT_W:0][AMT_W-1:0]  amt_pipe;
    logic [AMT_W:0]             fill_pipe;
    logic [AMT_W:0]             rev_pipe;
    op_kind_e                   kind_pipe [AMT_W+1];
`ifdef SHIFT_FLAGS_EN
    logic [AMT_W:0]             carry_pipe;
`endif

    // Left ops run as right ops on the bit-reversed operand.
    always_comb begin
        kind_pipe[0] = K_PASS;
        rev_pipe[0]  = 1'b0;
        case (mode)
            SH_SLL:  begin kind_pipe[0] = K_SHR; rev_pipe[0] = 1'b1; end
            SH_SRL:  kind_pipe[0] = K_SHR;
            SH_SRA:  kind_pipe[0] = K_SHR;
            SH_ROR:  kind_pipe[0] = K_ROR;
            SH_ROL:  begin kind_pipe[0] = K_ROR; rev_pipe[0] = 1'b1; end
            default: kind_pipe[0] = K_PASS;
        endcase
    end

    assign vld_pipe[0]  = in_valid;
    assign in_ready     = rdy_pipe[0];
    assign dat_pipe[0]  = rev_pipe[0] ? WIDTH'(bit_rev(SH_MAX_W'(indata), WIDTH)) : indata;
    assign amt_pipe[0]  = amount;
    assign fill_pipe[0] = (mode == SH_SRA) && indata[WIDTH-1];
`ifdef SHIFT_FLAGS_EN
    assign carry_pipe[0] = 1'b0;
`endif

    generate
        for (genvar k = 0; k < AMT_W; k++) begin : g_stage
            shift_stage #(
                .WIDTH (WIDTH),
                .STEP  ((k == AMT_W - 1) ? WIDTH : (1 << k)),
                .AMT_W (AMT_W)
            ) u_stage (
                .clk       (clk),
                .reset_n   (reset_n),
                .in_valid  (vld_pipe[k]),
                .in_ready  (rdy_pipe[k]),
                .in_data   (dat_pipe[k]),
                .in_amt    (amt_pipe[k]),
                .in_kind   (kind_pipe[k]),
                .in_fill   (fill_pipe[k]),
                .in_rev    (rev_pipe[k]),
`ifdef SHIFT_FLAGS_EN
                .in_carry  (carry_pipe[k]),
                .out_carry (carry_pipe[k+1]),
`endif
                .out_valid (vld_pipe[k+1]),
                .out_ready (rdy_pipe[k+1]),
                .out_data  (dat_pipe[k+1]),
                .out_amt   (amt_pipe[k+1]),
                .out_kind  (kind_pipe[k+1]),
                .out_fill  (fill_pipe[k+1]),
                .out_rev   (rev_pipe[k+1])
            );
        end
    endgenerate

    assign rdy_pipe[AMT_W] = out_ready;
    assign out_valid       = vld_pipe[AMT_W];
    assign outdata         = rev_pipe[AMT_W] ? WIDTH'(bit_rev(SH_MAX_W'(dat_pipe[AMT_W]), WIDTH))
                                             : dat_pipe[AMT_W];

`ifdef SHIFT_FLAGS_EN
    assign out_zero  = vld_pipe[AMT_W] && (outdata == '0);
    assign out_carry = carry_pipe[AMT_W];
`endif

    // Control fields of the last stage have no consumer beyond the pipe.
    logic unused_tail;
    assign unused_tail = ^{amt_pipe[AMT_W], kind_pipe[AMT_W], fill_pipe[AMT_W]};

endmodule
